// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state type and active-high hex segment patterns for the scan driver.
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/seg7_scan_driver_sync_edge_det.sv
// sync_edge_det: two-flop synchroniser with a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic s1, s2, prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      prev <= s2;
    end
  end
  assign rise = s2 & ~prev;
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexes a hex value onto a 7-segment display, one digit per scanClk edge.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic                  bigClk,
  input  logic                  reset,
  input  logic                  scanClk,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  logic tick;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [4*DIGITS-1:0] disp, disp_n, pend;
  logic pend_full, cap, wrap, frame, swap, on;
  logic [DIGITS-1:0] vis, an_hi;
  logic [6:0] seg_hi;
  logic [3:0] nib;
  sync_edge_det u_sync (
    .clk(bigClk),
    .rst(reset),
    .din(scanClk),
    .rise(tick)
  );
  always_comb begin
    cap = load_valid && load_ready;
    wrap = idx == IW'(DIGITS - 1);
    frame = tick && (state == IDLE || (state == SHOW && wrap));
    swap = frame && pend_full;
    state_n = state == BLANK ? (cnt == CW'(BLANK_CYCLES - 1) ? SHOW : BLANK) : (tick ? BLANK : state);
    cnt_n = (state == BLANK && cnt != CW'(BLANK_CYCLES - 1)) ? cnt + CW'(1) : '0;
    idx_n = frame ? '0 : (state == SHOW && tick) ? idx + IW'(1) : idx;
    disp_n = swap ? pend : disp;
  end
  // Visibility looks at the value being shown next cycle so a swap never shows a stale mask.
  always_comb begin
    vis = '0;
    for (int i = 0; i < DIGITS; i++)
      vis[i] = !LZ_SUPPRESS || i == 0 || (|(disp_n >> (4 * i)));
    nib = disp_n[4*idx_n +: 4];
    on = state_n == SHOW && vis[idx_n];
    seg_hi = on ? hex_to_seg(nib) : '0;
    an_hi = on ? DIGITS'(1) << idx_n : '0;
  end
  always_ff @(posedge bigClk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      disp <= '0;
      pend <= '0;
      pend_full <= 1'b0;
      load_ready <= 1'b1;
      frame_start <= 1'b0;
      seg <= {7{ACTIVE_LOW}};
      an <= {DIGITS{ACTIVE_LOW}};
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      disp <= disp_n;
      pend <= cap ? value_i : pend;
      pend_full <= cap | (pend_full & ~swap);
      // Ready rises one cycle after the swap empties the pending slot.
      load_ready <= ~pend_full & ~cap;
      frame_start <= frame;
      seg <= seg_hi ^ {7{ACTIVE_LOW}};
      an <= an_hi ^ {DIGITS{ACTIVE_LOW}};
    end
  end
endmodule
